mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, sets the maximum wait cycles in ACCESS before a timeout error (legal range 1..255).
REQ-002 Parameter CNT_W, default 16, sets the width of the stall statistics counter.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 reset_i  input  1  reset, synchronous, active-high.
REQ-005 mem_read_im  input  1  instruction in Memory stage performs a load.
REQ-006 mem_write_im  input  1  instruction in Memory stage performs a store.
REQ-007 enable_wreg_im  input  1  Memory-stage register-write enable, ungated.
REQ-008 mem_ready_i  input  1  data memory completes the requested access this cycle.
REQ-009 mem_req_o  output  1  data memory access request.
REQ-010 mem_we_o  output  1  write strobe; valid only while mem_req_o=1.
REQ-011 stall_o  output  1  freezes the Fetch through Memory stages, including the EX/MEM register.
REQ-012 wb_bubble_o  output  1  forces a bubble into the Memory/Writeback register this cycle.
REQ-013 enable_wreg_gated_o  output  1  enable_wreg_im AND NOT wb_bubble_o; drives the Memory/Writeback register-write enable.
REQ-014 mem_err_o  output  1  sticky memory-timeout flag.
REQ-015 stall_cnt_o  output  CNT_W  saturating count of stall cycles since reset.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCESS and ERROR. Outputs are Mealy: a function of state, inputs and wait_cnt.
REQ-017 The internal access flag SHALL be acc = mem_read_im OR mem_write_im. mem_we_o = mem_write_im whenever mem_req_o=1; a store takes priority when both inputs are high. mem_we_o = 0 otherwise.
REQ-018 IDLE, acc=0: mem_req_o=0, stall_o=0, wb_bubble_o=0; next state IDLE.
REQ-019 IDLE, acc=1, mem_ready_i=1 (zero-wait): mem_req_o=1, stall_o=0, wb_bubble_o=0; next state IDLE.
REQ-020 IDLE, acc=1, mem_ready_i=0: mem_req_o=1, stall_o=1, wb_bubble_o=1; next state ACCESS; wait_cnt loads 1.
REQ-021 ACCESS, mem_ready_i=1: mem_req_o=1, stall_o=0, wb_bubble_o=0 (the instruction advances into Writeback this cycle); next state IDLE; wait_cnt clears to 0.
REQ-022 ACCESS, mem_ready_i=0, wait_cnt<TIMEOUT: mem_req_o=1, stall_o=1, wb_bubble_o=1; wait_cnt increments by 1.
REQ-023 ACCESS, mem_ready_i=0, wait_cnt==TIMEOUT: mem_req_o=1, stall_o=1, wb_bubble_o=1; next state ERROR; mem_err_o sets on that edge.
REQ-024 ERROR: mem_req_o=0, stall_o=1, wb_bubble_o=1, mem_err_o=1. mem_ready_i and acc are ignored. The block leaves ERROR only on reset.
REQ-025 A late mem_ready_i SHALL be honoured with ready taking priority over timeout: mem_ready_i=1 in the same cycle as wait_cnt==TIMEOUT completes normally per REQ-021.
REQ-026 Inputs mem_read_im, mem_write_im and enable_wreg_im SHALL be held stable by the stalled pipeline during ACCESS. The block does not re-sample acc in ACCESS.
REQ-027 stall_cnt_o SHALL increment by 1 on every edge where stall_o=1 and reset_i=0, and saturate at 2^CNT_W-1 with no wrap.
REQ-028 Latency: a zero-wait access adds 0 stall cycles. An access with ready first seen N cycles after the request (N<=TIMEOUT) stalls exactly N cycles.

Reset
REQ-029 On any edge with reset_i=1 the block SHALL set state=IDLE, wait_cnt=0, mem_err_o=0 and stall_cnt_o=0, including when reset is asserted mid-ACCESS or in ERROR.
REQ-030 While reset_i=1, mem_req_o, mem_we_o, stall_o and wb_bubble_o SHALL be forced to 0, and enable_wreg_gated_o SHALL equal enable_wreg_im.
REQ-031 The first cycle after reset deassertion SHALL behave as IDLE per REQ-018 to REQ-020.

Verification
REQ-032 Zero-wait load: mem_read_im=1 and mem_ready_i=1 in IDLE -> mem_req_o=1, stall_o=0, enable_wreg_gated_o=1, stall_cnt_o stays 0.
REQ-033 Three-wait store: mem_write_im=1, ready asserted on the 4th request cycle -> stall_o=1 for exactly 3 cycles, mem_we_o=1 on all 4 cycles, stall_cnt_o=3, enable_wreg_gated_o=0 during the stall.
REQ-034 Timeout: TIMEOUT=4, load with ready never asserted -> ERROR entered after 5 request cycles, mem_err_o=1, mem_req_o=0, stall_o=1 held; later mem_ready_i=1 has no effect.
REQ-035 Boundary: TIMEOUT=4, ready asserted exactly when wait_cnt==4 -> normal completion, mem_err_o stays 0, 4 stall cycles counted.
REQ-036 Reset mid-ACCESS at wait_cnt=2 -> outputs 0 during reset, state=IDLE and stall_cnt_o=0 after the edge; a new zero-wait access then completes with no stall.
REQ-037 Saturation: CNT_W=4, hold in ERROR for 20 cycles -> stall_cnt_o reaches 15 and stays at 15.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
//
// Purpose:
//   Handshake controller for the Memory stage of a pipelined core. It issues
//   data-memory requests for loads/stores. It stalls the front of the pipeline
//   while the memory is not ready, and injects bubbles into the MEM/WB register.
//   It traps into a sticky error state when an access waits longer than
//   TIMEOUT cycles. A saturating counter records the total number of stall
//   cycles since reset.
//
// Parameters:
//   TIMEOUT  maximum wait cycles in ACCESS before a timeout (1..255)
//   CNT_W    width of the stall statistics counter
//
// Ports:
//   clk_i                in   clock, rising edge
//   reset_i              in   synchronous, active-high reset
//   mem_read_im          in   Memory-stage instruction is a load
//   mem_write_im         in   Memory-stage instruction is a store
//   enable_wreg_im       in   ungated Memory-stage register-write enable
//   mem_ready_i          in   data memory completes the access this cycle
//   mem_req_o            out  data memory access request
//   mem_we_o             out  write strobe (only meaningful with mem_req_o)
//   stall_o              out  freeze Fetch..Memory, including EX/MEM
//   wb_bubble_o          out  force a bubble into MEM/WB this cycle
//   enable_wreg_gated_o  out  enable_wreg_im with bubbles masked out
//   mem_err_o            out  sticky timeout flag
//   stall_cnt_o          out  saturating stall-cycle count
// -----------------------------------------------------------------------------
module mem_stage_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             mem_read_im,
  input  logic             mem_write_im,
  input  logic             enable_wreg_im,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             stall_o,
  output logic             wb_bubble_o,
  output logic             enable_wreg_gated_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERROR  = 2'd2
  } state_t;

  localparam logic [7:0]       TIMEOUT_VAL = 8'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  state_t           state_reg, state_next;
  logic [7:0]       wait_cnt_reg, wait_cnt_next;
  logic             err_reg, err_next;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic acc;
  logic req;
  logic stall;
  logic bubble;

  assign acc = mem_read_im | mem_write_im;

  // ---------------------------------------------------------------------------
  // Next-state and Mealy outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    err_next      = err_reg;
    req           = 1'b0;
    stall         = 1'b0;
    bubble        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (acc) begin
          req = 1'b1;
          // A ready memory completes in the request cycle with no stall.
          if (!mem_ready_i) begin
            stall         = 1'b1;
            bubble        = 1'b1;
            state_next    = ACCESS;
            wait_cnt_next = 8'd1;
          end
        end
      end

      ACCESS: begin
        // acc is not re-sampled here: the stalled pipeline holds it steady.
        req = 1'b1;
        if (mem_ready_i) begin
          // Ready wins over the timeout, even on the final wait cycle.
          state_next    = IDLE;
          wait_cnt_next = 8'd0;
        end else if (wait_cnt_reg < TIMEOUT_VAL) begin
          stall         = 1'b1;
          bubble        = 1'b1;
          wait_cnt_next = 8'(wait_cnt_reg + 8'd1);
        end else begin
          stall      = 1'b1;
          bubble     = 1'b1;
          state_next = ERROR;
          err_next   = 1'b1;
        end
      end

      ERROR: begin
        // Terminal until reset: the pipeline stays frozen, with no requests.
        stall  = 1'b1;
        bubble = 1'b1;
      end

      default: begin
        state_next    = IDLE;
        wait_cnt_next = 8'd0;
      end
    endcase

    // Reset masks all pipeline-control outputs, whatever the state.
    if (reset_i) begin
      req    = 1'b0;
      stall  = 1'b0;
      bubble = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= 8'd0;
      err_reg       <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      err_reg      <= err_next;
      if (stall && (stall_cnt_reg != CNT_MAX)) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_req_o           = req;
  assign mem_we_o            = req & mem_write_im;  // store wins over a load
  assign stall_o             = stall;
  assign wb_bubble_o         = bubble;
  assign enable_wreg_gated_o = enable_wreg_im & ~bubble;
  assign mem_err_o           = err_reg;
  assign stall_cnt_o         = stall_cnt_reg;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_ctrl
//
// Directed self-checking bench for mem_stage_ctrl. It uses TIMEOUT=4 and
// CNT_W=4, so the timeout, boundary and saturation cases can all be reached
// in one short run. Inputs are driven just after the rising edge. Outputs are
// checked mid-cycle.
// -----------------------------------------------------------------------------
module tb_mem_stage_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  logic             clk;
  logic             reset;
  logic             mem_read;
  logic             mem_write;
  logic             enable_wreg;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             stall;
  logic             wb_bubble;
  logic             enable_wreg_gated;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  int checks_done;
  int checks_failed;

  mem_stage_ctrl #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .mem_read_im        (mem_read),
    .mem_write_im       (mem_write),
    .enable_wreg_im     (enable_wreg),
    .mem_ready_i        (mem_ready),
    .mem_req_o          (mem_req),
    .mem_we_o           (mem_we),
    .stall_o            (stall),
    .wb_bubble_o        (wb_bubble),
    .enable_wreg_gated_o(enable_wreg_gated),
    .mem_err_o          (mem_err),
    .stall_cnt_o        (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_done++;
    if (got !== exp) begin
      checks_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let the combinational outputs settle before checking them.
  task automatic settle();
    #2;
  endtask

  initial begin
    checks_done   = 0;
    checks_failed = 0;
    reset       = 1'b1;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    enable_wreg = 1'b1;
    mem_ready   = 1'b0;

    // ---- Reset: outputs forced low, gated enable follows the raw enable ----
    tick();
    mem_read = 1'b1;
    settle();
    check("rst_req", mem_req, 0);
    check("rst_stall", stall, 0);
    check("rst_bubble", wb_bubble, 0);
    check("rst_gated", enable_wreg_gated, 1);
    check("rst_err", mem_err, 0);
    check("rst_cnt", stall_cnt, 0);
    mem_read = 1'b0;
    tick();
    reset = 1'b0;

    // ---- Zero-wait load ----
    mem_read  = 1'b1;
    mem_ready = 1'b1;
    settle();
    check("zw_req", mem_req, 1);
    check("zw_we", mem_we, 0);
    check("zw_stall", stall, 0);
    check("zw_gated", enable_wreg_gated, 1);
    tick();
    check("zw_cnt", stall_cnt, 0);

    // ---- Three-wait store: ready on the 4th request cycle ----
    mem_read  = 1'b0;
    mem_write = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("st3_req_c%0d", i), mem_req, 1);
      check($sformatf("st3_we_c%0d", i), mem_we, 1);
      check($sformatf("st3_stall_c%0d", i), stall, 1);
      check($sformatf("st3_gated_c%0d", i), enable_wreg_gated, 0);
      tick();
    end
    mem_ready = 1'b1;
    settle();
    check("st3_req_done", mem_req, 1);
    check("st3_we_done", mem_we, 1);
    check("st3_stall_done", stall, 0);
    check("st3_gated_done", enable_wreg_gated, 1);
    tick();
    check("st3_cnt", stall_cnt, 3);
    mem_write = 1'b0;
    mem_ready = 1'b0;
    settle();
    check("idle_req", mem_req, 0);
    check("idle_stall", stall, 0);
    tick();

    // ---- Boundary: ready exactly when wait_cnt == TIMEOUT ----
    mem_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("bnd_stall_c%0d", i), stall, 1);
      tick();
    end
    mem_ready = 1'b1;
    settle();
    check("bnd_req_done", mem_req, 1);
    check("bnd_stall_done", stall, 0);
    check("bnd_bubble_done", wb_bubble, 0);
    tick();
    check("bnd_err", mem_err, 0);
    check("bnd_cnt", stall_cnt, 7);

    // ---- Reset mid-ACCESS at wait_cnt == 2 ----
    mem_ready = 1'b0;
    tick();               // IDLE -> ACCESS, wait_cnt = 1
    tick();               // wait_cnt = 2
    check("mid_cnt_pre", stall_cnt, 9);
    reset       = 1'b1;
    enable_wreg = 1'b0;
    settle();
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_we", mem_we, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_bubble", wb_bubble, 0);
    check("mid_rst_gated", enable_wreg_gated, 0);
    tick();
    reset       = 1'b0;
    enable_wreg = 1'b1;
    mem_ready   = 1'b1;
    settle();
    check("mid_post_cnt", stall_cnt, 0);
    check("mid_post_req", mem_req, 1);
    check("mid_post_stall", stall, 0);
    tick();
    check("mid_post_cnt2", stall_cnt, 0);

    // ---- Timeout: ready never arrives, ERROR after 5 request cycles ----
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check($sformatf("to_req_c%0d", i), mem_req, 1);
      check($sformatf("to_stall_c%0d", i), stall, 1);
      check($sformatf("to_err_c%0d", i), mem_err, 0);
      tick();
    end
    settle();
    check("to_err", mem_err, 1);
    check("to_req", mem_req, 0);
    check("to_stall", stall, 1);
    check("to_cnt", stall_cnt, 5);
    mem_ready = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b1;
    settle();
    check("err_ready_req", mem_req, 0);
    check("err_ready_we", mem_we, 0);
    check("err_ready_stall", stall, 1);
    check("err_ready_gated", enable_wreg_gated, 0);

    // ---- Saturation: 20 more cycles in ERROR ----
    for (int i = 0; i < 20; i++) tick();
    check("sat_cnt", stall_cnt, 15);
    check("sat_err", mem_err, 1);
    tick();
    check("sat_cnt_hold", stall_cnt, 15);

    // ---- Reset clears ERROR ----
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    mem_write = 1'b0;
    mem_ready = 1'b0;
    settle();
    check("clr_err", mem_err, 0);
    check("clr_cnt", stall_cnt, 0);
    check("clr_stall", stall, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks_done, checks_failed);
    $finish;
  end

endmodule
